// File: rtl/hex_sched_pkg.sv
// Shared types, constants and the round-robin pick function for the
// hex display scheduler.
package hex_sched_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam int   MAX_NREQ  = 8;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First requester with req high, searching upward from ptr and wrapping at nreq.
  function automatic logic [2:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                         input logic [2:0]          ptr,
                                         input int                  nreq);
    logic [2:0] pick;
    logic       found;
    int         cand;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= nreq) cand = cand - nreq;
      if (k < nreq && !found && req[cand]) begin
        pick  = 3'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Nibble to active-low 7-segment pattern (bit 6 = g, bit 0 = a); the single
// decoder shared by all requesters.
module hex_seg_decode
  import hex_sched_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    // NOTE: default assigned before the case so no path leaves seg unassigned (no latch).
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0011000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_sched.sv
// Round-robin scheduler sharing one 7-segment decoder across NREQ requesters.
// Define HEX_ATOMIC_EN to stage all digits and update HEX together on entry to DONE.
module hex_display_sched
  import hex_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int NDIG = 6,
  localparam int OW   = idx_w(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*4*NDIG-1:0] data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [OW-1:0]          owner,
  output logic [7*NDIG-1:0]      HEX
);

  localparam int IW = idx_w(NDIG);
  localparam int DW = 4 * NDIG;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [OW-1:0]   rr_q;
  logic [DW-1:0]   shadow_q;
  logic [2:0]      pick;
  logic            any_req;
  logic            last_digit;
  logic [3:0]      nibble;
  seg_t            seg;

  assign any_req    = |req;
  assign pick       = rr_pick(MAX_NREQ'(req), 3'(rr_q), NREQ);
  assign last_digit = (idx_q == IW'(NDIG - 1));
  assign nibble     = shadow_q[idx_q*4 +: 4];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  hex_seg_decode u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

`ifdef HEX_ATOMIC_EN
  logic [7*NDIG-1:0] stage_q, stage_d;

  always_comb begin
    stage_d              = stage_q;
    stage_d[idx_q*7 +: 7] = seg;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = SCAN;
      SCAN:    if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt   <= '0;
      owner <= '0;
      idx_q <= '0;
      rr_q  <= '0;
      HEX   <= {NDIG{SEG_BLANK}};
    end else begin
      gnt <= '0;
      unique case (state_q)
        IDLE: if (any_req) begin
          owner <= OW'(pick);
          gnt   <= NREQ'(1) << pick;
          idx_q <= '0;
        end
        SCAN: begin
          idx_q <= last_digit ? '0 : idx_q + 1'b1;
`ifdef HEX_ATOMIC_EN
          if (last_digit) HEX <= stage_d;
`else
          HEX[idx_q*7 +: 7] <= seg;
`endif
        end
        DONE:    rr_q <= (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: snapshot/staging storage is always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && any_req) shadow_q <= data[int'(pick)*DW +: DW];
`ifdef HEX_ATOMIC_EN
    if (state_q == SCAN) stage_q <= stage_d;
`endif
  end

endmodule

// File: tb/tb_hex_display_sched.sv
// Self-checking bench for hex_display_sched: a transaction timeline model
// predicts every output each cycle, plus literal scenario checks.
module tb_hex_display_sched;

  localparam int NREQ = 2;
  localparam int NDIG = 6;
  localparam int DW   = NREQ * 4 * NDIG;
  localparam int HW   = 7 * NDIG;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  localparam logic [HW-1:0] HEX_BLANK = {NDIG{7'h7F}};
  localparam logic [HW-1:0] HEX_REF   = {7'b1000000, 7'b1111001, 7'b0100100,
                                         7'b0110000, 7'b0001000, 7'b0001110};
`ifdef HEX_ATOMIC_EN
  localparam logic [HW-1:0] HEX_MID   = HEX_BLANK;
`else
  localparam logic [HW-1:0] HEX_MID   = {7'h7F, 7'h7F, 7'h7F,
                                         7'b0110000, 7'b0001000, 7'b0001110};
`endif

  logic            clk;
  logic            reset_n;
  logic [NREQ-1:0] req;
  logic [DW-1:0]   data;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic [0:0]      owner;
  logic [HW-1:0]   HEX;

  int n_checks = 0;
  int n_fail   = 0;

  hex_display_sched #(.NREQ(NREQ), .NDIG(NDIG)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .owner   (owner),
    .HEX     (HEX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a grant at edge t0 means busy over edges t0..t0+NDIG,
  // digit d visible from edge t0+1+d, done at t0+NDIG, next arbitration at t0+NDIG+2.
  int              m_cyc;
  int              m_t0;
  int              m_owner;
  bit              m_have_prev;
  logic [4*NDIG-1:0] m_snap;
  logic [6:0]      m_hex [NDIG];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc       = 0;
      m_t0        = -1;
      m_owner     = 0;
      m_have_prev = 0;
      for (int d = 0; d < NDIG; d++) m_hex[d] = 7'h7F;
    end else begin
      m_cyc++;
      if ((m_t0 < 0 || m_cyc >= m_t0 + NDIG + 2) && (|req)) begin
        int ptr;
        int win;
        ptr = m_have_prev ? (m_owner + 1) % NREQ : 0;
        win = -1;
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && req[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
        m_t0        = m_cyc;
        m_owner     = win;
        m_have_prev = 1;
        m_snap      = data[win*4*NDIG +: 4*NDIG];
      end
      if (m_t0 >= 0 && m_cyc > m_t0 && m_cyc <= m_t0 + NDIG) begin
`ifdef HEX_ATOMIC_EN
        if (m_cyc == m_t0 + NDIG)
          for (int d = 0; d < NDIG; d++) m_hex[d] = SEG_TAB[m_snap[d*4 +: 4]];
`else
        m_hex[m_cyc - m_t0 - 1] = SEG_TAB[m_snap[(m_cyc - m_t0 - 1)*4 +: 4]];
`endif
      end
    end
  end

  always @(posedge clk) begin
    logic [HW-1:0]   e_hex;
    logic [NREQ-1:0] e_gnt;
    #1;
    for (int d = 0; d < NDIG; d++) e_hex[d*7 +: 7] = m_hex[d];
    e_gnt = (m_t0 >= 0 && m_cyc == m_t0) ? NREQ'(1) << m_owner : '0;
    check("cyc_gnt",   64'(gnt),   64'(e_gnt));
    check("cyc_busy",  64'(busy),  64'(m_t0 >= 0 && m_cyc <= m_t0 + NDIG));
    check("cyc_done",  64'(done),  64'(m_t0 >= 0 && m_cyc == m_t0 + NDIG));
    check("cyc_owner", 64'(owner), 64'(m_owner));
    check("cyc_hex",   64'(HEX),   64'(e_hex));
  end

  task automatic wait_gnt(output int at);
    at = -1;
    for (int n = 0; n < 40 && at < 0; n++) begin
      @(posedge clk);
      #1;
      if (gnt != '0) at = m_cyc;
    end
    if (at < 0) check("gnt_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int n = 0; n < 40 && at < 0; n++) begin
      @(posedge clk);
      #1;
      if (done) at = m_cyc;
    end
    if (at < 0) check("done_timeout", 64'(0), 64'(1));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  initial begin
    int t_g, t_d, t_a, t_b;
    int tg [4];
    logic [NREQ-1:0] gg [4];

    reset_n = 1'b0;
    req     = '0;
    data    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex",   64'(HEX),   64'(HEX_BLANK));
    check("rst_gnt",   64'(gnt),   64'(0));
    check("rst_busy",  64'(busy),  64'(0));
    check("rst_done",  64'(done),  64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_hex",  64'(HEX),  64'(HEX_BLANK));

    // Single request from requester 0
    data[23:0] = 24'h0123AF;
    req        = 2'b01;
    wait_gnt(t_g);
    check("single_gnt", 64'(gnt), 64'(2'b01));
    @(negedge clk);
    req  = '0;
    data = rnd_data();
    repeat (3) @(posedge clk);
    #1;
    check("single_mid_hex", 64'(HEX), 64'(HEX_MID));
    wait_done(t_d);
    check("single_latency", 64'(t_d - t_g), 64'(NDIG));
    check("single_hex",     64'(HEX),       64'(HEX_REF));
    check("single_owner",   64'(owner),     64'(0));

    // Contention: both held high, grants must alternate starting at 1
    @(negedge clk);
    req  = 2'b11;
    data = rnd_data();
    for (int i = 0; i < 4; i++) begin
      wait_gnt(tg[i]);
      gg[i] = gnt;
      @(negedge clk);
      data = rnd_data();
      if (i == 3) req = '0;
    end
    check("cont_g0", 64'(gg[0]), 64'(2'b10));
    check("cont_g1", 64'(gg[1]), 64'(2'b01));
    check("cont_g2", 64'(gg[2]), 64'(2'b10));
    check("cont_g3", 64'(gg[3]), 64'(2'b01));
    for (int i = 0; i < 3; i++) check("cont_spacing", 64'(tg[i+1] - tg[i]), 64'(NDIG + 2));
    wait_done(t_d);

    // Late request arriving mid-scan
    @(negedge clk);
    req  = 2'b01;
    data = rnd_data();
    wait_gnt(t_a);
    @(negedge clk) req = '0;
    repeat (2) @(negedge clk);
    req = 2'b10;
    wait_gnt(t_b);
    check("late_gnt",     64'(gnt),         64'(2'b10));
    check("late_spacing", 64'(t_b - t_a),   64'(NDIG + 2));
    @(negedge clk) req = '0;
    wait_done(t_d);

    // Random traffic
    repeat (400) begin
      @(negedge clk);
      req  = NREQ'($urandom());
      data = rnd_data();
    end
    @(negedge clk) req = '0;
    repeat (12) @(negedge clk);

    // Reset after digit 2 of a transfer is written
    req  = 2'b01;
    data = rnd_data();
    wait_gnt(t_g);
    @(negedge clk) req = '0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_hex",  64'(HEX),  64'(HEX_BLANK));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_gnt",  64'(gnt),  64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    data[23:0] = 24'h0123AF;
    req        = 2'b01;
    wait_gnt(t_g);
    @(negedge clk) req = '0;
    wait_done(t_d);
    check("post_rst_latency", 64'(t_d - t_g), 64'(NDIG));
    check("post_rst_hex",     64'(HEX),       64'(HEX_REF));
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
